// File: rtl/wb_lsu_master_if.sv
// Wishbone classic bus bundle between the LSU master and its responders.
interface wb_lsu_master_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = DATA_W / 8;

  logic [ADDR_W-1:0] wb_addr_o;
  logic [DATA_W-1:0] wb_dat_o;
  logic [SEL_W-1:0]  wb_sel_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              wb_err_i;

  modport master (
    output wb_addr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_addr_o, wb_dat_o, wb_sel_o, wb_cyc_o, wb_stb_o, wb_we_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/wb_lsu_master.sv
// Wishbone classic initiator: one bus cycle per core load/store, one response per request.
// Optional watchdog on unanswered cycles is compiled in with WB_LSU_MASTER_TIMEOUT_EN.
module wb_lsu_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_misaligned,
  wb_lsu_master_if.master wb
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SEL_W  = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_BUS, ST_RESP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        size_q;
  logic              unsigned_q;
  logic              go_bus, go_fault, term_ok, term_err;
  logic              size_bad, misaligned, timeout_c;
  logic [SEL_W-1:0]  sel_c;
  logic [DATA_W-1:0] wmask_c;

  // Request classification in IDLE
  assign size_bad   = (req_size == 2'd3);
  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  always_comb begin
    case (req_size)
      2'd0:    sel_c = 4'h1;
      2'd1:    sel_c = 4'h3;
      default: sel_c = 4'hf;
    endcase
  end

  assign wmask_c = {{8{sel_c[3]}}, {8{sel_c[2]}}, {8{sel_c[1]}}, {8{sel_c[0]}}};

  function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] d,
                                                    input logic [1:0] size,
                                                    input logic uns);
    logic [DATA_W-1:0] r;
    case (size)
      2'd0:    r = {{24{~uns & d[7]}}, d[7:0]};
      2'd1:    r = {{16{~uns & d[15]}}, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

`ifdef WB_LSU_MASTER_TIMEOUT_EN
  localparam int unsigned CNT_REQ_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CNT_W     = (CNT_REQ_W > 8) ? CNT_REQ_W : 8;

  logic [CNT_W-1:0] wdog_q;

  // Counts unterminated BUS cycles; held at zero outside BUS so entry starts clean
  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_BUS)) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_q + CNT_W'(1);
    end
  end

  assign timeout_c = (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and transfer strobes; error outranks ack, ack outranks the watchdog
  always_comb begin
    state_d  = state_q;
    go_bus   = 1'b0;
    go_fault = 1'b0;
    term_ok  = 1'b0;
    term_err = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          if (size_bad || misaligned) begin
            go_fault = 1'b1;
            state_d  = ST_RESP;
          end else begin
            go_bus  = 1'b1;
            state_d = ST_BUS;
          end
        end
      end
      ST_BUS: begin
        if (wb.wb_err_i) begin
          term_err = 1'b1;
          state_d  = ST_RESP;
        end else if (wb.wb_ack_i) begin
          term_ok = 1'b1;
          state_d = ST_RESP;
        end else if (timeout_c) begin
          term_err = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Registered bus and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_err        <= 1'b0;
      rsp_misaligned <= 1'b0;
      wb.wb_cyc_o    <= 1'b0;
      wb.wb_stb_o    <= 1'b0;
      wb.wb_we_o     <= 1'b0;
      wb.wb_sel_o    <= '0;
      wb.wb_addr_o   <= '0;
      wb.wb_dat_o    <= '0;
      size_q         <= 2'd0;
      unsigned_q     <= 1'b0;
    end else begin
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_RESP);
      if (go_bus) begin
        wb.wb_cyc_o  <= 1'b1;
        wb.wb_stb_o  <= 1'b1;
        wb.wb_we_o   <= req_we;
        wb.wb_sel_o  <= sel_c;
        wb.wb_addr_o <= req_addr;
        wb.wb_dat_o  <= req_wdata & wmask_c;
        size_q       <= req_size;
        unsigned_q   <= req_unsigned;
      end
      if (go_fault) begin
        rsp_rdata      <= '0;
        rsp_err        <= size_bad;
        rsp_misaligned <= ~size_bad;
      end
      if (term_ok || term_err) begin
        wb.wb_cyc_o    <= 1'b0;
        wb.wb_stb_o    <= 1'b0;
        wb.wb_we_o     <= 1'b0;
        rsp_err        <= term_err;
        rsp_misaligned <= 1'b0;
        rsp_rdata      <= (term_err || wb.wb_we_o) ? '0
                          : load_extend(wb.wb_dat_i, size_q, unsigned_q);
      end
    end
  end

endmodule

// File: tb/tb_wb_lsu_master.sv
// Self-checking bench for wb_lsu_master: directed vector table, corner sequences, random vs. model.
module tb_wb_lsu_master;
`ifdef WB_LSU_MASTER_TIMEOUT_EN
  localparam bit          TO_EN = 1'b1;
  localparam int unsigned TO    = 4;
`else
  localparam bit          TO_EN = 1'b0;
  localparam int unsigned TO    = 255;
`endif
  localparam int BOUND  = 40;
  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdat;
    int          lat;    // stb-high cycles before the responder terminates
    int          kind;
    bit          noise;  // ack/err asserted while idle
  } txn_t;

  typedef struct packed {
    int          lat;    // accept edge to rsp_valid cycle
    int          stb_n;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    logic [31:0] rdata;
    logic        err;
    logic        mis;
    bit          bus_ok;
    bit          pulse_ok;
    bit          hung;
  } obs_t;

  typedef struct packed {
    txn_t t;
    obs_t e;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err, rsp_misaligned;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  wb_lsu_master_if bus();

  wb_lsu_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_size       (req_size),
    .req_unsigned   (req_unsigned),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_err        (rsp_err),
    .rsp_misaligned (rsp_misaligned),
    .wb             (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic txn_t mkt(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdat, input int lat, input int kind,
                               input bit noise);
    txn_t t;
    t = '0;
    t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata;
    t.rdat = rdat; t.lat = lat; t.kind = kind; t.noise = noise;
    return t;
  endfunction

  function automatic obs_t mke(input int lat, input int stb_n, input logic [3:0] sel,
                               input logic [31:0] dat, input logic [31:0] rdata,
                               input logic err, input logic mis);
    obs_t e;
    e = '0;
    e.lat = lat; e.stb_n = stb_n; e.sel = sel; e.dat = dat; e.rdata = rdata;
    e.err = err; e.mis = mis; e.bus_ok = 1'b1; e.pulse_ok = 1'b1;
    return e;
  endfunction

  // Reference model: outcome derived arithmetically from access size, alignment and responder behaviour
  function automatic obs_t model(input txn_t t);
    obs_t            m;
    int unsigned     n;
    longint unsigned lim, fld;
    int              term_at;
    m = '0;
    m.bus_ok = 1'b1;
    m.pulse_ok = 1'b1;
    if (t.size == 2'd3) begin
      m.lat = 1; m.err = 1'b1;
      return m;
    end
    n = 32'd1 << t.size;
    if ((t.addr % n) != 0) begin
      m.lat = 1; m.mis = 1'b1;
      return m;
    end
    lim   = 64'd1 << (8 * n);
    m.sel = 4'((32'd1 << n) - 1);
    m.dat = 32'(64'(t.wdata) % lim);
    term_at = (t.kind == K_NONE) ? 4 * BOUND : t.lat + 1;
    if (TO_EN && term_at > int'(TO)) begin
      m.stb_n = int'(TO);
      m.err   = 1'b1;
    end else begin
      m.stb_n = term_at;
      m.err   = (t.kind != K_ACK);
    end
    m.lat = m.stb_n + 1;
    if (!m.err && !t.we) begin
      fld = 64'(t.rdat) % lim;
      if (!t.uns && fld >= lim / 2) fld = fld + (64'h1_0000_0000 - lim);
      m.rdata = 32'(fld);
    end
    return m;
  endfunction

  // Presents one request, plays the responder and records what the DUT did
  task automatic run_txn(input txn_t t, output obs_t o);
    int  waitc;
    bit  done, first;
    o = '0;
    o.bus_ok = 1'b1;
    done = 1'b0;
    first = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = t.we; req_size = t.size; req_unsigned = t.uns;
    req_addr = t.addr; req_wdata = t.wdata; bus.wb_dat_i = t.rdat;
    bus.wb_ack_i = t.noise; bus.wb_err_i = t.noise;
    waitc = 0;
    while (!req_ready && waitc < BOUND) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      o.hung = 1'b1;
      req_valid = 1'b0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= BOUND && !done; c++) begin
      bus.wb_ack_i = 1'b0;
      bus.wb_err_i = 1'b0;
      if (rsp_valid) begin
        done = 1'b1;
        o.lat = c; o.rdata = rsp_rdata; o.err = rsp_err; o.mis = rsp_misaligned;
        if (bus.wb_stb_o || bus.wb_cyc_o) o.bus_ok = 1'b0;
      end else if (bus.wb_stb_o) begin
        o.stb_n++;
        if (bus.wb_cyc_o !== 1'b1) o.bus_ok = 1'b0;
        if (first) begin
          first = 1'b0;
          o.sel = bus.wb_sel_o; o.we = bus.wb_we_o; o.addr = bus.wb_addr_o; o.dat = bus.wb_dat_o;
        end else if (bus.wb_sel_o !== o.sel || bus.wb_we_o !== o.we ||
                     bus.wb_addr_o !== o.addr || bus.wb_dat_o !== o.dat) begin
          o.bus_ok = 1'b0;
        end
        if (o.stb_n == t.lat + 1) begin
          bus.wb_ack_i = (t.kind == K_ACK) || (t.kind == K_BOTH);
          bus.wb_err_i = (t.kind == K_ERR) || (t.kind == K_BOTH);
        end
      end else if (bus.wb_cyc_o) begin
        o.bus_ok = 1'b0;
      end
      if (!done) @(negedge clk);
    end
    if (!done) begin
      o.hung = 1'b1;
      return;
    end
    @(negedge clk);
    o.pulse_ok = !rsp_valid && !bus.wb_stb_o && !bus.wb_cyc_o && req_ready;
  endtask

  task automatic check_obs(input string tag, input txn_t t, input obs_t g, input obs_t e);
    chk({tag, " hung"}, 32'(g.hung), 32'(0));
    if (!g.hung) begin
      chk({tag, " latency"}, g.lat, e.lat);
      chk({tag, " stb_cycles"}, g.stb_n, e.stb_n);
      chk({tag, " rdata"}, g.rdata, e.rdata);
      chk({tag, " err"}, 32'(g.err), 32'(e.err));
      chk({tag, " misaligned"}, 32'(g.mis), 32'(e.mis));
      chk({tag, " bus_stable"}, 32'(g.bus_ok), 32'(e.bus_ok));
      chk({tag, " one_pulse_idle"}, 32'(g.pulse_ok), 32'(e.pulse_ok));
      if (e.stb_n > 0) begin
        chk({tag, " sel"}, 32'(g.sel), 32'(e.sel));
        chk({tag, " we"}, 32'(g.we), 32'(t.we));
        chk({tag, " addr"}, g.addr, t.addr);
        if (t.we) chk({tag, " dat_o"}, g.dat, e.dat);
      end
    end
  endtask

  vec_t vecs [14];
  txn_t t;
  obs_t g;
  int   quiet;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;

    vecs[0]  = '{mkt(0, 2, 0, 32'h0,  32'h11111111, 32'h00001297, 1, K_ACK, 0),
                 mke(3, 2, 4'hf, 32'h0, 32'h00001297, 0, 0)};
    vecs[1]  = '{mkt(0, 0, 0, 32'h10, 32'h0, 32'h12345680, 1, K_ACK, 0),
                 mke(3, 2, 4'h1, 32'h0, 32'hFFFFFF80, 0, 0)};
    vecs[2]  = '{mkt(0, 0, 1, 32'h10, 32'h0, 32'h12345680, 1, K_ACK, 0),
                 mke(3, 2, 4'h1, 32'h0, 32'h00000080, 0, 0)};
    vecs[3]  = '{mkt(1, 1, 0, 32'h2,  32'hDEADBEEF, 32'h12345678, 1, K_ACK, 0),
                 mke(3, 2, 4'h3, 32'h0000BEEF, 32'h0, 0, 0)};
    vecs[4]  = '{mkt(0, 2, 0, 32'h6,  32'h0, 32'h0, 1, K_ACK, 1),
                 mke(1, 0, 4'h0, 32'h0, 32'h0, 0, 1)};
    vecs[5]  = '{mkt(0, 3, 0, 32'h0,  32'h0, 32'h0, 1, K_ACK, 0),
                 mke(1, 0, 4'h0, 32'h0, 32'h0, 1, 0)};
    vecs[6]  = '{mkt(0, 2, 0, 32'h20, 32'h0, 32'hCAFEF00D, 1, K_BOTH, 0),
                 mke(3, 2, 4'hf, 32'h0, 32'h0, 1, 0)};
    vecs[7]  = '{mkt(0, 2, 0, 32'h24, 32'h0, 32'h89ABCDEF, 0, K_ERR, 0),
                 mke(2, 1, 4'hf, 32'h0, 32'h0, 1, 0)};
    vecs[8]  = '{mkt(0, 1, 0, 32'h6,  32'h0, 32'h00008001, 3, K_ACK, 0),
                 mke(5, 4, 4'h3, 32'h0, 32'hFFFF8001, 0, 0)};
    vecs[9]  = '{mkt(1, 1, 0, 32'h1,  32'h12345678, 32'h0, 0, K_ACK, 0),
                 mke(1, 0, 4'h0, 32'h0, 32'h0, 0, 1)};
    vecs[10] = '{mkt(1, 0, 0, 32'h3,  32'hAABBCCDD, 32'h0, 0, K_ACK, 0),
                 mke(2, 1, 4'h1, 32'h000000DD, 32'h0, 0, 0)};
    vecs[11] = '{mkt(1, 2, 0, 32'h8,  32'h01234567, 32'hFFFFFFFF, 2, K_ACK, 1),
                 mke(4, 3, 4'hf, 32'h01234567, 32'h0, 0, 0)};
    vecs[12] = '{mkt(0, 1, 1, 32'hA,  32'h0, 32'hFFFFF00F, 0, K_ACK, 0),
                 mke(2, 1, 4'h3, 32'h0, 32'h0000F00F, 0, 0)};
    vecs[13] = '{mkt(0, 3, 0, 32'h3,  32'h0, 32'h0, 0, K_ACK, 0),
                 mke(1, 0, 4'h0, 32'h0, 32'h0, 1, 0)};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'(0));
    chk("reset rsp_valid", 32'(rsp_valid), 32'(0));
    chk("reset rsp_flags", {30'd0, rsp_err, rsp_misaligned}, 32'(0));
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset cyc_stb_we", {29'd0, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o}, 32'(0));
    chk("reset sel", 32'(bus.wb_sel_o), 32'(0));
    chk("reset addr", bus.wb_addr_o, 32'h0);
    chk("reset dat_o", bus.wb_dat_o, 32'h0);
    rst = 1'b0;

    // Directed vector table
    foreach (vecs[i]) begin
      run_txn(vecs[i].t, g);
      check_obs($sformatf("vec%0d", i), vecs[i].t, g, vecs[i].e);
    end

    // Response outputs hold after the pulse
    run_txn(vecs[1].t, g);
    check_obs("hold_pre", vecs[1].t, g, vecs[1].e);
    repeat (3) @(negedge clk);
    chk("hold rsp_valid", 32'(rsp_valid), 32'(0));
    chk("hold rsp_rdata", rsp_rdata, 32'hFFFFFF80);
    chk("hold rsp_err", 32'(rsp_err), 32'(0));

`ifdef WB_LSU_MASTER_TIMEOUT_EN
    // Silent responder: watchdog ends the cycle
    t = mkt(0, 2, 0, 32'h30, 32'h0, 32'h5555AAAA, 0, K_NONE, 0);
    run_txn(t, g);
    check_obs("timeout", t, g, mke(5, 4, 4'hf, 32'h0, 32'h0, 1, 0));
`endif

    // Reset in the middle of a bus cycle: responder stays silent
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h40;
    quiet = 0;
    while (!req_ready && quiet < BOUND) begin
      @(negedge clk);
      quiet++;
    end
    chk("rst_bus accepted", 32'(req_ready), 32'(1));
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rst_bus stb before rst", 32'(bus.wb_stb_o), 32'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_bus cyc_stb low", {30'd0, bus.wb_cyc_o, bus.wb_stb_o}, 32'(0));
    chk("rst_bus no rsp", 32'(rsp_valid), 32'(0));
    rst = 1'b0;
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || bus.wb_stb_o || bus.wb_cyc_o) quiet++;
    end
    chk("rst_bus quiet after", quiet, 0);
    run_txn(vecs[0].t, g);
    check_obs("rst_bus recover", vecs[0].t, g, vecs[0].e);

    // Randomized traffic against the model
    for (int i = 0; i < 150; i++) begin
      int k;
      t = '0;
      t.we    = 1'($urandom_range(0, 1));
      t.size  = 2'($urandom_range(0, 3));
      t.uns   = 1'($urandom_range(0, 1));
      t.addr  = $urandom;
      if ($urandom_range(0, 3) != 0) t.addr = t.addr & ~32'h3;
      t.wdata = $urandom;
      t.rdat  = $urandom;
      t.lat   = int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 5));
      t.kind  = (k < 3) ? K_ACK : (k == 3) ? K_ERR : (k == 4) ? K_BOTH : (TO_EN ? K_NONE : K_ACK);
      t.noise = ($urandom_range(0, 3) == 0);
      run_txn(t, g);
      check_obs($sformatf("rnd%0d", i), t, g, model(t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_lsu_master.md
# wb_lsu_master

Wishbone classic initiator that converts single load/store requests from the core's memory stage into one bus cycle each, toward the block RAM and other Wishbone responders. Generates byte-select from access size, rejects misaligned or illegal accesses without touching the bus, sign/zero-extends load data, and returns exactly one response per accepted request. An optional watchdog terminates cycles whose responder never acknowledges.

## Interface
- TIMEOUT_CYCLES, 255, number of cycles with stb_o high and no ack_i/err_i before the master self-terminates with error (used only with the watchdog compiled in); must be ≥1.
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  high only in IDLE; request accepted on an edge where req_valid & req_ready
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  one-cycle pulse, one per accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  bus error, timeout, or illegal size
- rsp_misaligned  out  1  alignment fault (no bus cycle issued)
- wb_addr_o  out  32  byte address
- wb_dat_o  out  32  store data, right-justified
- wb_sel_o  out  4  byte 4'h1, half 4'h3, word 4'hf
- wb_cyc_o, wb_stb_o  out  1 each  always driven identically
- wb_we_o  out  1  write enable
- wb_dat_i  in  32  read data, right-justified
- wb_ack_i, wb_err_i  in  1 each  responder termination

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On accept, register we/size/unsigned/addr/wdata. Misaligned (half with addr[0]=1, word with addr[1:0]≠0) or size=3 → RESP directly with rsp_misaligned=1 (alignment) or rsp_err=1 (size=3); otherwise → BUS.
- BUS: cyc/stb/we/addr/sel/dat_o driven from registers, held stable. Sample each edge: err_i → RESP with rsp_err=1; else ack_i → RESP, capture load data; else watchdog expiry → RESP with rsp_err=1.
- RESP: rsp_valid=1 for one cycle, cyc/stb low; → IDLE.
- Load extension: byte uses wb_dat_i[7:0], half uses [15:0], word uses [31:0]; upper bits = 0 if unsigned else replicated top bit of the field. Stores: wb_dat_o = req_wdata with unused upper bits masked to 0.
- ack_i/err_i ignored outside BUS.

## Timing
- Reset values: req_ready=0 during rst then 1 in IDLE; rsp_valid=0, rsp_err=0, rsp_misaligned=0, rsp_rdata=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_sel_o=0, wb_addr_o=0, wb_dat_o=0; state IDLE.
- Accept at edge N → stb high in cycle N+1. Termination sampled at edge M → stb low and rsp_valid high in cycle M+1. Zero-wait responder (ack in cycle after stb): accept-to-rsp_valid = 3 cycles. Faulted request: rsp_valid in cycle N+1, no bus activity.
- ack_i and err_i same edge: error wins, rsp_rdata=0.
- Back-to-back: next request accepted no earlier than the edge ending RESP; one idle bus cycle between transactions.
- rst mid-BUS: cyc/stb low next cycle, no response emitted, pending request discarded.
- Response outputs other than rsp_valid hold value until next RESP.

## Configuration
- WB_LSU_MASTER_TIMEOUT_EN defined: 8-bit-or-wider counter cleared on BUS entry, increments each BUS cycle without termination; when count reaches TIMEOUT_CYCLES, terminate with rsp_err=1.
- Not defined: no counter; BUS waits indefinitely for ack_i/err_i.

## Test plan
- Word load addr 0x0, responder returns 0x00001297 one cycle after stb → sel=4'hf, we=0, rsp_valid 3 cycles after accept, rsp_rdata=0x00001297, rsp_err=0.
- Signed byte load addr 0x10, dat_i[7:0]=0x80 → rsp_rdata=0xFFFFFF80; same with req_unsigned=1 → 0x00000080.
- Half store addr 0x2, wdata 0xDEADBEEF → sel=4'h3, we=1, wb_dat_o=0x0000BEEF; rsp_valid after ack, rsp_rdata=0.
- Word load addr 0x6 → no cyc/stb, rsp_valid next cycle with rsp_misaligned=1; size=3 at addr 0x0 → rsp_err=1.
- ack_i and err_i together → rsp_err=1, rsp_rdata=0; err_i alone → rsp_err=1.
- With WB_LSU_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → stb high exactly 4 cycles, then rsp_err=1; rst asserted in BUS → cyc/stb low next cycle, no rsp_valid.
